// File: rtl/sddt_cmd_pkg.sv
// Shared DDR command definitions: word width, opcode field, refresh command, arbiter state encoding.
package sddt_cmd_pkg;

    localparam int CMD_W   = 128;
    localparam int OPC_MSB = 127;
    localparam int OPC_LSB = 120;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OPC_REF = 8'h0A;

    // All-bank refresh: opcode in the top byte, every other field zero.
    localparam logic [CMD_W-1:0] REF_CMD = CMD_W'(OPC_REF) << OPC_LSB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOST = 2'd1,
        ST_REF  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream register slice: registered output, registered ready, full throughput.
module axis_skid_buf #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] skid_data;
    logic         skid_valid;
    logic         live;
    logic         in_fire;

    // live keeps ready low through reset and the first cycle after release.
    assign in_ready = live & ~skid_valid;
    assign in_fire  = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live       <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else begin
            live <= 1'b1;
            if (out_ready || !out_valid) begin
                if (skid_valid) begin
                    out_data   <= skid_data;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= in_fire;
                    if (in_fire) out_data <= in_data;
                end
            end else if (in_fire) begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Merges host command groups with periodic refresh commands into one stream toward the DDR core.
// Optional statistics counters are built only when CMD_ARB_STATS_EN is defined.
module cmd_arbiter
    import sddt_cmd_pkg::*;
#(
    parameter int TREFI_CYCLES    = 5200,
    parameter int REF_MAX_PENDING = 8,
    parameter int REF_URGENT      = 4
) (
    input  logic             axi_aclk,
    input  logic             axi_aresetn,
    input  logic             ref_en,
    input  logic [CMD_W-1:0] S_AXIS_CMD_tdata,
    input  logic             S_AXIS_CMD_tvalid,
    input  logic             S_AXIS_CMD_tlast,
    output logic             S_AXIS_CMD_tready,
    output logic [CMD_W-1:0] M_AXIS_CMD_tdata,
    output logic             M_AXIS_CMD_tvalid,
    input  logic             M_AXIS_CMD_tready,
    output logic [3:0]       ref_pending,
    output logic             ref_overflow,
    output logic [31:0]      stat_host_beats,
    output logic [31:0]      stat_ref_issued
);

    localparam int TW = (TREFI_CYCLES > 1) ? $clog2(TREFI_CYCLES) : 1;

    arb_state_t       state, state_nxt;
    logic [TW-1:0]    timer;
    logic [3:0]       pending;
    logic             due;
    logic             ref_go;
    logic             host_sel, ref_sel;
    logic             ref_fire;
    logic             buf_ready;
    logic             buf_valid;
    logic [CMD_W-1:0] buf_data;

    assign due = ref_en && (timer == TW'(TREFI_CYCLES - 1));

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn)  timer <= '0;
        else if (!ref_en)  timer <= '0;
        else if (due)      timer <= '0;
        else               timer <= timer + TW'(1);
    end

    // Refresh goes first when urgent, or opportunistically when the host is quiet.
    assign ref_go = ref_en && ((pending >= 4'(REF_URGENT)) ||
                               (pending != 4'd0 && !S_AXIS_CMD_tvalid));

    always_comb begin
        state_nxt = state;
        host_sel  = 1'b0;
        ref_sel   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ref_go) begin
                    state_nxt = ST_REF;
                end else if (S_AXIS_CMD_tvalid) begin
                    host_sel = 1'b1;
                    // A single-beat group taken here never leaves IDLE.
                    if (!(buf_ready && S_AXIS_CMD_tlast)) state_nxt = ST_HOST;
                end
            end
            ST_HOST: begin
                host_sel = 1'b1;
                if (S_AXIS_CMD_tvalid && buf_ready && S_AXIS_CMD_tlast) state_nxt = ST_IDLE;
            end
            ST_REF: begin
                ref_sel = 1'b1;
                if (buf_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state <= ST_IDLE;
        else              state <= state_nxt;
    end

    assign S_AXIS_CMD_tready = host_sel & buf_ready;
    assign ref_fire          = ref_sel & buf_ready;
    assign buf_valid         = ref_sel ? 1'b1 : (host_sel & S_AXIS_CMD_tvalid);
    assign buf_data          = ref_sel ? REF_CMD : S_AXIS_CMD_tdata;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pending      <= '0;
            ref_overflow <= 1'b0;
        end else begin
            if (due && pending == 4'(REF_MAX_PENDING)) ref_overflow <= 1'b1;
            case ({due, ref_fire})
                2'b10:   if (pending != 4'(REF_MAX_PENDING)) pending <= pending + 4'd1;
                2'b01:   if (pending != 4'd0) pending <= pending - 4'd1;
                default: pending <= pending;
            endcase
        end
    end

    assign ref_pending = pending;

    axis_skid_buf #(.W(CMD_W)) u_skid (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .in_data   (buf_data),
        .in_valid  (buf_valid),
        .in_ready  (buf_ready),
        .out_data  (M_AXIS_CMD_tdata),
        .out_valid (M_AXIS_CMD_tvalid),
        .out_ready (M_AXIS_CMD_tready)
    );

`ifdef CMD_ARB_STATS_EN
    logic        host_fire;
    logic [31:0] host_cnt, ref_cnt;

    assign host_fire = S_AXIS_CMD_tvalid & S_AXIS_CMD_tready;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            host_cnt <= '0;
            ref_cnt  <= '0;
        end else begin
            if (host_fire) host_cnt <= host_cnt + 32'd1;
            if (ref_fire)  ref_cnt  <= ref_cnt + 32'd1;
        end
    end

    assign stat_host_beats = host_cnt;
    assign stat_ref_issued = ref_cnt;
`else
    assign stat_host_beats = '0;
    assign stat_ref_issued = '0;
`endif

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter (TREFI=16, max pending 8, urgent at 4) with a queue-driven host and stream monitor.
module tb_cmd_arbiter;
    import sddt_cmd_pkg::*;

    localparam int TREFI = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ref_en = 1'b0;
    logic [CMD_W-1:0] S_tdata = '0;
    logic             S_tvalid = 1'b0;
    logic             S_tlast = 1'b0;
    logic             S_tready;
    logic [CMD_W-1:0] M_tdata;
    logic             M_tvalid;
    logic             M_tready = 1'b1;
    logic [3:0]       ref_pending;
    logic             ref_overflow;
    logic [31:0]      stat_host_beats, stat_ref_issued;

    always #5 clk = ~clk;

    cmd_arbiter #(.TREFI_CYCLES(TREFI), .REF_MAX_PENDING(8), .REF_URGENT(4)) dut (
        .axi_aclk          (clk),
        .axi_aresetn       (rst_n),
        .ref_en            (ref_en),
        .S_AXIS_CMD_tdata  (S_tdata),
        .S_AXIS_CMD_tvalid (S_tvalid),
        .S_AXIS_CMD_tlast  (S_tlast),
        .S_AXIS_CMD_tready (S_tready),
        .M_AXIS_CMD_tdata  (M_tdata),
        .M_AXIS_CMD_tvalid (M_tvalid),
        .M_AXIS_CMD_tready (M_tready),
        .ref_pending       (ref_pending),
        .ref_overflow      (ref_overflow),
        .stat_host_beats   (stat_host_beats),
        .stat_ref_issued   (stat_ref_issued)
    );

    typedef struct packed { logic l; logic [CMD_W-1:0] d; } beat_t;

    beat_t            in_q[$];
    logic [CMD_W-1:0] out_q[$], exp_q[$];
    int               out_t[$], in_t[$];
    int               cyc = 0;
    bit               s_fire = 0;
    int               rdy_mode = 1;
    int               n_tests = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes seen at the falling edge complete on the next rising edge (cyc+1).
    always @(negedge clk) begin
        if (rst_n) begin
            if (M_tvalid && M_tready) begin
                out_q.push_back(M_tdata);
                out_t.push_back(cyc + 1);
            end
            if (S_tvalid && S_tready) begin
                s_fire = 1;
                in_t.push_back(cyc + 1);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (s_fire) begin
            s_fire = 0;
            if (in_q.size() > 0) in_q.delete(0);
        end
        if (in_q.size() > 0) begin
            S_tvalid = 1'b1;
            S_tdata  = in_q[0].d;
            S_tlast  = in_q[0].l;
        end else begin
            S_tvalid = 1'b0;
            S_tlast  = 1'b0;
        end
        case (rdy_mode)
            0:       M_tready = 1'b0;
            1:       M_tready = 1'b1;
            default: M_tready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string tag, input logic [CMD_W-1:0] got, input logic [CMD_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [CMD_W-1:0] d, input logic l);
        in_q.push_back({l, d});
        exp_q.push_back(d);
    endtask

    // Ends at posedge+1 with the output stage already accepting.
    task automatic do_reset();
        rst_n = 1'b0;
        in_q.delete();
        s_fire   = 0;
        ref_en   = 1'b0;
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        out_q.delete(); out_t.delete(); in_t.delete(); exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic wait_out(input int n, input int lim, input string tag);
        int k = 0;
        while (out_q.size() < n && k < lim) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk({tag, " out count reached"}, 128'(out_q.size() >= n), 128'(1));
    endtask

    task automatic wait_drain(input int lim, input string tag);
        int k = 0;
        while (in_q.size() > 0 && k < lim) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " input drained"}, 128'(in_q.size()), 128'(0));
    endtask

    function automatic int nth_ref(input int n);
        int seen = 0;
        foreach (out_q[i]) begin
            if (out_q[i] == REF_CMD) begin
                if (seen == n) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic int ref_count();
        int c = 0;
        foreach (out_q[i]) if (out_q[i] == REF_CMD) c++;
        return c;
    endfunction

    task automatic chk_host(input string tag);
        logic [CMD_W-1:0] h[$];
        foreach (out_q[i]) if (out_q[i] != REF_CMD) h.push_back(out_q[i]);
        chk({tag, " host count"}, 128'(h.size()), 128'(exp_q.size()));
        for (int i = 0; i < h.size() && i < exp_q.size(); i++)
            chk($sformatf("%s beat %0d", tag, i), h[i], exp_q[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CMD_W-1:0] d;

        // reset state
        #12;
        chk("rst pending", 128'(ref_pending), 128'(0));
        chk("rst overflow", 128'(ref_overflow), 128'(0));
        chk("rst m_valid", 128'(M_tvalid), 128'(0));
        chk("rst s_ready", 128'(S_tready), 128'(0));
        chk("rst stat host", 128'(stat_host_beats), 128'(0));
        chk("rst stat ref", 128'(stat_ref_issued), 128'(0));
        do_reset();

        // idle host: one refresh every TREFI cycles, drained each time
        ref_en = 1'b1;
        repeat (84) @(posedge clk); #1;
        chk("t1 ref count", 128'(out_q.size()), 128'(5));
        chk("t1 all refs", 128'(ref_count()), 128'(5));
        if (out_t.size() >= 2) chk("t1 spacing", 128'(out_t[1] - out_t[0]), 128'(TREFI));
        chk("t1 pending", 128'(ref_pending), 128'(0));
        ref_en = 1'b0;
        repeat (40) @(posedge clk); #1;
        chk("t1 disabled count", 128'(out_q.size()), 128'(5));
        ref_en = 1'b1;
        repeat (18) @(posedge clk); #1;
        chk("t1 timer restart early", 128'(out_q.size()), 128'(5));
        @(posedge clk); #1;
        chk("t1 timer restart due", 128'(out_q.size()), 128'(6));

        // continuous single-beat groups: refresh only once pending hits 4
        do_reset();
        ref_en = 1'b1;
        for (int i = 0; i < 100; i++) push(128'h2000 + 128'(i), 1'b1);
        wait_drain(400, "t2");
        chk("t2 first ref idx", 128'(nth_ref(0)), 128'(64));
        chk("t2 second ref idx", 128'(nth_ref(1)), 128'(79));
        chk_host("t2");

        // 10-beat group straddling the urgent threshold stays contiguous
        do_reset();
        ref_en = 1'b1;
        for (int i = 0; i < 56; i++) push(128'h3000 + 128'(i), 1'b1);
        for (int i = 0; i < 10; i++) push(128'h3100 + 128'(i), i == 9);
        for (int i = 0; i < 10; i++) push(128'h3200 + 128'(i), 1'b1);
        wait_drain(400, "t3");
        chk("t3 ref after tlast", 128'(nth_ref(0)), 128'(66));
        if (out_q.size() > 65) chk("t3 tlast beat slot", out_q[65], 128'h3109);
        chk_host("t3");

        // long stall: pending saturates, overflow sticks, nothing lost on release
        do_reset();
        ref_en = 1'b1;
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) push(128'h4000 + 128'(i), i == 4);
        repeat (192) @(posedge clk); #1;
        chk("t4 pending sat", 128'(ref_pending), 128'(8));
        chk("t4 overflow", 128'(ref_overflow), 128'(1));
        chk("t4 m_valid held", 128'(M_tvalid), 128'(1));
        chk("t4 m_data held", M_tdata, 128'h4000);
        chk("t4 nothing out", 128'(out_q.size()), 128'(0));
        rdy_mode = 1;
        repeat (28) @(posedge clk); #1;
        chk("t4 pending drained", 128'(ref_pending), 128'(0));
        chk("t4 overflow sticky", 128'(ref_overflow), 128'(1));
        chk("t4 ref count", 128'(ref_count()), 128'(9));
        chk_host("t4");
`ifdef CMD_ARB_STATS_EN
        chk("t4 stat host", 128'(stat_host_beats), 128'(5));
        chk("t4 stat ref", 128'(stat_ref_issued), 128'(9));
`else
        chk("t4 stat host", 128'(stat_host_beats), 128'(0));
        chk("t4 stat ref", 128'(stat_ref_issued), 128'(0));
`endif

        // latency at full rate, then random back-pressure
        do_reset();
        chk("t5 overflow cleared", 128'(ref_overflow), 128'(0));
        for (int i = 0; i < 20; i++) push(128'h5000 + 128'(i), i == 19);
        wait_out(20, 200, "t5 burst");
        for (int i = 0; i < 20 && i < out_t.size() && i < in_t.size(); i++)
            chk($sformatf("t5 latency %0d", i), 128'(out_t[i] - in_t[i]), 128'(1));
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            d[OPC_MSB:OPC_LSB] = '0;
            push(d, ($urandom_range(0, 3) == 0) || i == 999);
        end
        wait_out(1020, 8000, "t5 random");
        rdy_mode = 1;
        chk_host("t5");

        // reset mid-group, then a fresh group passes intact
        do_reset();
        for (int i = 0; i < 6; i++) push(128'h6000 + 128'(i), i == 5);
        repeat (3) @(posedge clk); #2;
        chk("t6 pre-reset m_valid", 128'(M_tvalid), 128'(1));
        rst_n = 1'b0;
        in_q.delete(); exp_q.delete();
        s_fire = 0;
        #1;
        chk("t6 m_valid in reset", 128'(M_tvalid), 128'(0));
        chk("t6 s_ready in reset", 128'(S_tready), 128'(0));
        chk("t6 pending in reset", 128'(ref_pending), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_q.delete(); out_t.delete(); in_t.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) push(128'h7000 + 128'(i), i == 2);
        wait_out(3, 50, "t6");
        chk_host("t6");
`ifdef CMD_ARB_STATS_EN
        chk("t6 stat host", 128'(stat_host_beats), 128'(3));
`else
        chk("t6 stat host", 128'(stat_host_beats), 128'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 SHALL have parameter TREFI_CYCLES, default 5200, meaning the clock cycles between refresh-due events.
REQ-002 SHALL have parameter REF_MAX_PENDING, default 8, meaning the saturation limit of the pending-refresh count (DDR4 postpone limit).
REQ-003 SHALL have parameter REF_URGENT, default 4, meaning the pending count at or above which refresh preempts host traffic at the next group boundary.
REQ-004 SHALL have port axi_aclk, input, 1 bit: the sole clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port axi_aresetn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port ref_en, input, 1 bit: enables the refresh-due timer and refresh issue.
REQ-007 SHALL have ports S_AXIS_CMD_tdata (input, 128 bits), S_AXIS_CMD_tvalid (input, 1), S_AXIS_CMD_tlast (input, 1) and S_AXIS_CMD_tready (output, 1): host command stream; tlast closes an atomic group.
REQ-008 SHALL have ports M_AXIS_CMD_tdata (output, 128 bits), M_AXIS_CMD_tvalid (output, 1) and M_AXIS_CMD_tready (input, 1): merged command stream toward the DDR core.
REQ-009 SHALL have port ref_pending, output, 4 bits: current pending-refresh count.
REQ-010 SHALL have port ref_overflow, output, 1 bit: sticky flag, set on a due event while pending == REF_MAX_PENDING.
REQ-011 SHALL have ports stat_host_beats and stat_ref_issued, output, 32 bits each: statistics counters.

Function
REQ-012 SHALL use a timer counting 0..TREFI_CYCLES-1 while ref_en=1; the wrap cycle is a due event and increments pending, saturating at REF_MAX_PENDING.
REQ-013 SHALL hold the timer at 0 while ref_en=0; pending SHALL be retained.
REQ-014 SHALL implement states IDLE, HOST, REF:
- IDLE->REF if pending>=REF_URGENT, or pending>0 and S tvalid=0.
- IDLE->HOST if S tvalid=1, else.
- HOST->IDLE after the accepted beat with tlast=1.
- REF->IDLE after the REF_CMD word is accepted into the output stage.
REQ-015 SHALL not interrupt a host group mid-group; preemption SHALL occur only in IDLE.
REQ-016 SHALL decrement pending by one on each REF_CMD acceptance; a same-cycle due event and acceptance SHALL leave pending unchanged.
REQ-017 SHALL assert S_AXIS_CMD_tready only in HOST or IDLE-selecting-host, and only when the output stage can accept.
REQ-018 SHALL register the output through a skid buffer: 1-cycle latency and full throughput (1 beat/cycle when M tready=1).
REQ-019 SHALL hold M tdata/tvalid stable while tvalid=1 and tready=0, and SHALL preserve beat order.
REQ-020 SHALL keep ref_overflow set until reset.

Reset
REQ-021 SHALL, on axi_aresetn=0 (immediate), place state in IDLE and clear timer, pending, ref_overflow, skid contents, M tvalid, S tready and the stat counters.
REQ-022 SHALL discard a partially transferred host group on reset mid-group; after release, the first beat SHALL be treated as a group start.

Configuration
REQ-023 SHALL provide macro CMD_ARB_STATS_EN; when defined, stat_host_beats SHALL count accepted host beats and stat_ref_issued SHALL count accepted REF_CMD words, both wrapping at 2^32.
REQ-024 SHALL, when CMD_ARB_STATS_EN is undefined, tie both stat outputs to 0 and infer no counter logic.

Structure
REQ-025 SHALL take REF_CMD (128-bit refresh command word), the opcode field positions and the state encoding from shared package sddt_cmd_pkg.
REQ-026 SHALL place the skid buffer in one sub-module, axis_skid_buf (parameterised width, 2 entries).

Verification
REQ-027 SHALL cover: TREFI_CYCLES=16, host idle, ref_en=1 -> one REF_CMD on M every 16 cycles, ref_pending returns to 0.
REQ-028 SHALL cover: continuous 1-beat host groups, REF_URGENT=4 -> host continues until pending=4, then REF_CMD inserted between groups.
REQ-029 SHALL cover: 10-beat group, pending reaches 4 mid-group -> all 10 beats contiguous, REF_CMD follows the tlast beat.
REQ-030 SHALL cover: M tready=0 for 9*TREFI cycles -> pending=8, ref_overflow=1, no beat lost or duplicated after tready=1.
REQ-031 SHALL cover: random M tready back-pressure, 1000 host beats -> output order and data match input, with 1-cycle latency at tready=1.
REQ-032 SHALL cover: axi_aresetn pulse mid-group -> M tvalid=0 immediately, all state cleared, the next group passes intact.
